// File: rtl/me_move_sched.sv
// Keypad-driven craft move scheduler: synchronizes and debounces four direction keys,
// then issues evenly spaced step pulses with round-robin direction arbitration.
module me_move_sched #(
    parameter int DEB_CYC  = 16,
    parameter int STEP_DIV = 4
) (
    input  logic       clk_run,
    input  logic       rst,
    input  logic       en_i,
    input  logic       key_up_i,
    input  logic       key_down_i,
    input  logic       key_left_i,
    input  logic       key_right_i,
    output logic       move_en_o,
    output logic [1:0] direct_o,
    output logic       moving_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYC - 1);
    localparam logic [7:0] STEP_LAST = 8'(STEP_DIV - 1);

    logic [3:0]      w_keyRaw;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_deb;
    logic [3:0][7:0] r_debCnt;

    logic [3:0]      w_lvl;
    logic [3:0]      w_req;
    logic            w_reqAny;

    logic [0:0]      r_state;
    logic [0:0]      w_stateNext;
    logic [7:0]      r_stepCnt;
    logic            w_pulse;

    logic [1:0]      r_ptr;
    logic [1:0]      w_grant;
    logic [1:0]      w_idx;
    logic            w_found;

    // Bit order matches the request vector: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
    assign w_keyRaw = {key_right_i, key_left_i, key_down_i, key_up_i};

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_keyRaw;
            r_sync2 <= r_sync1;
        end
    end

    // A new level must persist DEB_CYC consecutive cycles before it is accepted.
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            r_deb    <= '0;
            r_debCnt <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_debCnt[k] <= '0;
                end else if (r_debCnt[k] == DEB_LAST) begin
                    r_deb[k]    <= r_sync2[k];
                    r_debCnt[k] <= '0;
                end else begin
                    r_debCnt[k] <= r_debCnt[k] + 8'd1;
                end
            end
        end
    end

    // Opposing keys held together cancel each other out.
    assign w_lvl    = r_deb & {4{en_i}};
    assign w_req[0] = w_lvl[0] & ~w_lvl[1];
    assign w_req[1] = w_lvl[1] & ~w_lvl[0];
    assign w_req[2] = w_lvl[2] & ~w_lvl[3];
    assign w_req[3] = w_lvl[3] & ~w_lvl[2];
    assign w_reqAny = |w_req;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: if (w_reqAny)  w_stateNext = ST_RUN;
            ST_RUN:  if (!w_reqAny) w_stateNext = ST_IDLE;
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign w_pulse = (r_state == ST_RUN) && (r_stepCnt == STEP_LAST) && w_reqAny;

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_stepCnt <= '0;
            moving_o  <= 1'b0;
            move_en_o <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            moving_o  <= (w_stateNext == ST_RUN);
            move_en_o <= w_pulse;
            if (r_state != ST_RUN || r_stepCnt == STEP_LAST) begin
                r_stepCnt <= '0;
            end else begin
                r_stepCnt <= r_stepCnt + 8'd1;
            end
        end
    end

    // Search starts just past the last grant so two held keys alternate.
    always_comb begin
        w_grant = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && w_req[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            r_ptr    <= 2'd3;
            direct_o <= 2'b00;
        end else if (w_pulse) begin
            r_ptr    <= w_grant;
            direct_o <= w_grant;
        end
    end

endmodule

// File: tb/tb_me_move_sched.sv
// Directed bench for me_move_sched with DEB_CYC=4, STEP_DIV=3; edge n means the
// n-th rising edge after the inputs change at the preceding falling edge.
module tb_me_move_sched;

    logic       clk_run;
    logic       rst;
    logic       en_i;
    logic       key_up_i;
    logic       key_down_i;
    logic       key_left_i;
    logic       key_right_i;
    logic       move_en_o;
    logic [1:0] direct_o;
    logic       moving_o;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    me_move_sched #(
        .DEB_CYC (4),
        .STEP_DIV(3)
    ) dut (
        .clk_run    (clk_run),
        .rst        (rst),
        .en_i       (en_i),
        .key_up_i   (key_up_i),
        .key_down_i (key_down_i),
        .key_left_i (key_left_i),
        .key_right_i(key_right_i),
        .move_en_o  (move_en_o),
        .direct_o   (direct_o),
        .moving_o   (moving_o)
    );

    initial clk_run = 1'b0;
    always #5 clk_run = ~clk_run;

    task automatic applyStimulus(input logic en, input logic up, input logic down,
                                 input logic left, input logic right);
        @(negedge clk_run);
        en_i        = en;
        key_up_i    = up;
        key_down_i  = down;
        key_left_i  = left;
        key_right_i = right;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk_run);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            waitEdges(1);
            checkOutput(tag, {3'b0, move_en_o}, 4'h0);
            checkOutput(tag, {3'b0, moving_o}, 4'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        en_i = 1'b1;
        key_up_i = 1'b0;
        key_down_i = 1'b0;
        key_left_i = 1'b0;
        key_right_i = 1'b0;
        #1;
        checkOutput("rst_move_en", {3'b0, move_en_o}, 4'h0);
        checkOutput("rst_moving", {3'b0, moving_o}, 4'h0);
        checkOutput("rst_direct", {2'b0, direct_o}, 4'h0);
        @(negedge clk_run);
        @(negedge clk_run);
        rst = 1'b0;
        checkQuiet("idle_quiet", 3);

        // Single RIGHT key: first pulse after edge 10, then every 3 edges.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        waitEdges(6);
        checkOutput("right_moving_e6", {3'b0, moving_o}, 4'h0);
        waitEdges(1);
        checkOutput("right_moving_e7", {3'b0, moving_o}, 4'h1);
        waitEdges(2);
        checkOutput("right_move_e9", {3'b0, move_en_o}, 4'h0);
        waitEdges(1);
        checkOutput("right_move_e10", {3'b0, move_en_o}, 4'h1);
        checkOutput("right_dir_e10", {2'b0, direct_o}, 4'h3);
        waitEdges(1);
        checkOutput("right_move_e11", {3'b0, move_en_o}, 4'h0);
        waitEdges(2);
        checkOutput("right_move_e13", {3'b0, move_en_o}, 4'h1);
        checkOutput("right_dir_e13", {2'b0, direct_o}, 4'h3);
        waitEdges(3);
        checkOutput("right_move_e16", {3'b0, move_en_o}, 4'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitEdges(8);
        checkOutput("right_rel_moving", {3'b0, moving_o}, 4'h0);
        checkOutput("right_rel_dir_hold", {2'b0, direct_o}, 4'h3);

        // UP+LEFT alternate, starting with UP.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        waitEdges(10);
        checkOutput("ul_move_e10", {3'b0, move_en_o}, 4'h1);
        checkOutput("ul_dir_e10", {2'b0, direct_o}, 4'h0);
        waitEdges(1);
        checkOutput("ul_dir_hold_e11", {2'b0, direct_o}, 4'h0);
        waitEdges(2);
        checkOutput("ul_move_e13", {3'b0, move_en_o}, 4'h1);
        checkOutput("ul_dir_e13", {2'b0, direct_o}, 4'h2);
        waitEdges(3);
        checkOutput("ul_dir_e16", {2'b0, direct_o}, 4'h0);
        waitEdges(3);
        checkOutput("ul_move_e19", {3'b0, move_en_o}, 4'h1);
        checkOutput("ul_dir_e19", {2'b0, direct_o}, 4'h2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitEdges(10);
        checkOutput("ul_rel_moving", {3'b0, moving_o}, 4'h0);

        // UP+DOWN cancel; releasing DOWN lets UP through after DOWN re-debounces.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkQuiet("ud_cancel", 12);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(7);
        checkOutput("ud_moving_e7", {3'b0, moving_o}, 4'h1);
        waitEdges(2);
        checkOutput("ud_move_e9", {3'b0, move_en_o}, 4'h0);
        waitEdges(1);
        checkOutput("ud_move_e10", {3'b0, move_en_o}, 4'h1);
        checkOutput("ud_dir_e10", {2'b0, direct_o}, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitEdges(10);
        checkOutput("ud_rel_moving", {3'b0, moving_o}, 4'h0);

        // LEFT glitch of 3 cycles is shorter than the debounce window.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        waitEdges(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkQuiet("left_glitch", 10);

        // DOWN held, en_i dropped for 5 edges mid-RUN, then restored.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        waitEdges(10);
        checkOutput("en_move_e10", {3'b0, move_en_o}, 4'h1);
        checkOutput("en_dir_e10", {2'b0, direct_o}, 4'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        waitEdges(1);
        checkOutput("en_low_moving", {3'b0, moving_o}, 4'h0);
        waitEdges(4);
        checkOutput("en_low_move", {3'b0, move_en_o}, 4'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        waitEdges(1);
        checkOutput("en_back_moving", {3'b0, moving_o}, 4'h1);
        waitEdges(2);
        checkOutput("en_back_move_e3", {3'b0, move_en_o}, 4'h0);
        waitEdges(1);
        checkOutput("en_back_move_e4", {3'b0, move_en_o}, 4'h1);
        checkOutput("en_back_dir_e4", {2'b0, direct_o}, 4'h1);

        // Reset in the middle of a pulse clears outputs at once.
        waitEdges(3);
        checkOutput("pre_rst_move", {3'b0, move_en_o}, 4'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_move", {3'b0, move_en_o}, 4'h0);
        checkOutput("mid_rst_moving", {3'b0, moving_o}, 4'h0);
        checkOutput("mid_rst_dir", {2'b0, direct_o}, 4'h0);
        @(negedge clk_run);
        @(negedge clk_run);
        rst = 1'b0;
        waitEdges(6);
        checkOutput("post_rst_moving_e6", {3'b0, moving_o}, 4'h0);
        waitEdges(1);
        checkOutput("post_rst_moving_e7", {3'b0, moving_o}, 4'h1);
        waitEdges(2);
        checkOutput("post_rst_move_e9", {3'b0, move_en_o}, 4'h0);
        waitEdges(1);
        checkOutput("post_rst_move_e10", {3'b0, move_en_o}, 4'h1);
        checkOutput("post_rst_dir_e10", {2'b0, direct_o}, 4'h1);

        // Request removed on the very edge a pulse would have fired.
        waitEdges(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        waitEdges(1);
        checkOutput("drop_at_wrap_move", {3'b0, move_en_o}, 4'h0);
        checkOutput("drop_at_wrap_moving", {3'b0, moving_o}, 4'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/me_move_sched.md
ME_MOVE_SCHED -- requirements
Module: me_move_sched

Interface
REQ-001 SHALL have parameter DEB_CYC, default 16, meaning consecutive clk_run cycles a synchronized key must hold a new level before its debounced state changes (range 1..255).
REQ-002 SHALL have parameter STEP_DIV, default 4, meaning clk_run cycles between consecutive move pulses (range 2..255).
REQ-003 SHALL have port clk_run  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en_i  input  1  game-running enable; low masks all requests.
REQ-006 SHALL have port key_up_i, key_down_i, key_left_i, key_right_i  input  1 each  raw asynchronous key levels, 1 = pressed.
REQ-007 SHALL have port move_en_o  output  1  one-cycle step pulse to the craft position logic.
REQ-008 SHALL have port direct_o  output  2  step direction; `UP=00, `DOWN=01, `LEFT=10, `RIGHT=11.
REQ-009 SHALL have port moving_o  output  1  high while FSM is in RUN.

Function
REQ-010 Each key SHALL pass a 2-flop synchronizer before any other use.
REQ-011 Each key SHALL have an independent debouncer: counter clears whenever synchronized level equals debounced level; otherwise increments; debounced level takes synchronized level and counter clears on the edge where the counter reaches DEB_CYC-1.
REQ-012 Request vector req[3:0] (index 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT) SHALL equal debounced levels ANDed with en_i, with UP/DOWN both cleared when both set and LEFT/RIGHT both cleared when both set.
REQ-013 FSM SHALL have states IDLE and RUN; IDLE->RUN on edge where req!=0; RUN->IDLE on edge where req==0; otherwise hold.
REQ-014 Step counter SHALL be cleared in IDLE and on IDLE->RUN; in RUN it SHALL increment each cycle and wrap to 0 on the edge where it equals STEP_DIV-1.
REQ-015 move_en_o SHALL be registered, high for exactly the one cycle following an edge where FSM is RUN, counter==STEP_DIV-1 and req!=0; low otherwise.
REQ-016 On each pulse, a round-robin arbiter SHALL grant the first set req bit searching upward (with wrap) from pointer+1; direct_o SHALL load that index on the same edge move_en_o rises; pointer SHALL load the granted index.
REQ-017 direct_o SHALL hold its last value between pulses and in IDLE.
REQ-018 With two non-cancelling keys held (e.g. UP+LEFT), grants SHALL alternate strictly; with one key, every grant SHALL be that key.
REQ-019 Key held continuously from before edge 0 (IDLE, debouncers settled low) SHALL give first move_en_o high after edge 3+DEB_CYC+STEP_DIV, then every STEP_DIV cycles.
REQ-020 en_i low SHALL force req=0 combinationally (FSM to IDLE next edge, no further pulses) while debouncers keep running; en_i returning high with keys held SHALL restart at REQ-014 with no re-debounce.
REQ-021 A request dropping on the same edge the counter reaches STEP_DIV-1 SHALL produce no pulse.
REQ-022 moving_o SHALL equal (state==RUN), registered.

Reset
REQ-023 rst high SHALL asynchronously set: state IDLE, step counter 0, all synchronizers, debounced levels and debounce counters 0, pointer 3 (first grant priority UP), move_en_o 0, direct_o 00, moving_o 0.
REQ-024 rst asserted mid-RUN SHALL drop move_en_o and moving_o immediately; after release, held keys SHALL be re-synchronized and re-debounced per REQ-019.

Verification (DEB_CYC=4, STEP_DIV=3)
REQ-025 Hold key_right_i from edge 0 -> move_en_o high after edges 10, 13, 16; direct_o=11 each pulse; moving_o high after edge 7.
REQ-026 Hold key_up_i+key_left_i -> direct_o sequence 00,10,00,10 on successive pulses.
REQ-027 Hold key_up_i+key_down_i -> no pulses, moving_o stays 0; release key_down_i -> UP pulses resume per debounce+step timing.
REQ-028 Toggle key_left_i high for 3 cycles only -> debounced level never changes, no pulse, moving_o 0.
REQ-029 Hold key_down_i, drop en_i for 5 cycles during RUN -> pulses stop, moving_o low after next edge; en_i high -> first pulse 4 edges later (IDLE->RUN edge + 3).
REQ-030 Assert rst while pulsing -> all outputs 0 immediately, direct_o=00; after release, first pulse again at edge 10 relative to release.
